// File: rtl/debug_uart_pkg.sv
// Shared definitions for the debug UART receive and transmit halves.
package debug_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;
    localparam state_t ST_BREAK = 3'd4;

    // Clocks per bit; truncating divide, shared with the transmitter.
    function automatic int calc_cpb(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input, with a selectable reset value.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debug_uart_rx.sv
// Debug UART receiver: 8N1 deserialiser with a one-byte holding register and sticky error flags.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit to confirm it is not a glitch
// DATA  | sampling eight data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; waiting for the line to return high
module debug_uart_rx
    import debug_uart_pkg::*;
#(
    parameter int CLK_HZ   = 64_000_000,
    parameter int BIT_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_read,
    input  logic       rx_clear_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

    logic          rxs;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          deliver_pend, deliver_next;
    logic          ferr_pend, ferr_next;

    logic [7:0]    data_next;
    logic          valid_next, overrun_next, frame_next, busy_next;
    logic          overrun_set;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rxd),
        .q   (rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shift        <= '0;
            bit_idx      <= '0;
            deliver_pend <= 1'b0;
            ferr_pend    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            shift        <= shift_next;
            bit_idx      <= bit_idx_next;
            deliver_pend <= deliver_next;
            ferr_pend    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = (cnt != '0) ? cnt - CW'(1) : cnt;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        deliver_next = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    cnt_next   = CNT_HALF;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                        cnt_next     = CNT_FULL;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    shift_next   = {rxs, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    cnt_next     = CNT_FULL;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    cnt_next = CNT_FULL;
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (rxs) begin
                        deliver_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        data_next    = rx_data;
        valid_next   = rx_valid;
        overrun_next = rx_overrun;
        frame_next   = rx_frame_err;
        overrun_set  = 1'b0;
        if (deliver_pend) begin
            if (!rx_valid || rx_read) begin
                data_next  = shift;
                valid_next = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (rx_read) begin
            valid_next = 1'b0;
        end
        if (rx_clear_err) begin
            overrun_next = 1'b0;
            frame_next   = 1'b0;
        end
        // Setting events override a simultaneous clear.
        if (overrun_set) begin
            overrun_next = 1'b1;
        end
        if (ferr_pend) begin
            frame_next = 1'b1;
        end
        busy_next = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_data      <= data_next;
            rx_valid     <= valid_next;
            rx_overrun   <= overrun_next;
            rx_frame_err <= frame_next;
            rx_busy      <= busy_next;
        end
    end

endmodule

// File: doc/debug_uart_rx.md
# debug_uart_rx

Receive half of the debug UART: samples a synchronised 8N1 serial line at a fixed bit rate and holds one received byte for the CPU. It sits beside the existing debug UART transmitter at the top level and uses the same `CLK_HZ`/`BIT_RATE` parameterisation. A read strobe consumes the byte. Overrun and framing errors are sticky flags for the data/status registers.

## Interface
- `CLK_HZ`, default 64_000_000: core clock frequency in Hz.
- `BIT_RATE`, default 9600: baud rate. `CPB = CLK_HZ/BIT_RATE` (integer divide; 6666 at defaults). Counter width is `$clog2(CPB)`. `CPB >= 4` is required.
- `clk  in  1`: core clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `uart_rxd  in  1`: asynchronous serial input; idle high.
- `rx_read  in  1`: one-cycle pulse that consumes the held byte.
- `rx_clear_err  in  1`: one-cycle pulse that clears both error flags.
- `rx_data  out  8`: held byte; valid while `rx_valid`.
- `rx_valid  out  1`: holding register full.
- `rx_overrun  out  1`: sticky; a byte was dropped because the holding register was full.
- `rx_frame_err  out  1`: sticky; a stop bit was sampled low.
- `rx_busy  out  1`: high in every state except IDLE.

## Operation
- **Synchroniser:** 2 flops, both reset to 1. Everything below uses the synchronised signal `rxs`.
- **Bit counter `cnt`:** decrements every cycle. Sampling happens when `cnt == 0`, and `cnt` is reloaded at that point.
- **IDLE:** when `rxs == 0`, go to START and load `cnt = CPB/2 - 1`.
- **START:** at `cnt == 0`, sample `rxs`.
  - If 1 (glitch): return to IDLE; no flag is set.
  - If 0: go to DATA, set `bit_idx = 0`, load `cnt = CPB - 1`.
- **DATA:** at each `cnt == 0`, shift right with `rxs` inserted at bit 7 (LSB first), increment `bit_idx`, reload `cnt = CPB - 1`. After the 8th sample (`bit_idx` wraps 7→0), go to STOP.
- **STOP:** at `cnt == 0`, sample `rxs`.
  - If 1: deliver the byte and go to IDLE. The FSM returns to IDLE at mid-stop-bit, so back-to-back frames are supported.
  - If 0: set `rx_frame_err`, discard the byte, go to BREAK.
- **BREAK:** wait for `rxs == 1`, then go to IDLE. A held-low line produces exactly one framing error and no phantom frames.
- **Deliver (holding-register rules):**
  - `rx_valid == 0`: `rx_data <= shift`, `rx_valid <= 1`.
  - `rx_valid == 1` and `rx_read` in the same cycle: new byte loaded, `rx_valid` stays 1, no overrun.
  - `rx_valid == 1` without `rx_read`: new byte dropped, old `rx_data` kept, `rx_overrun <= 1`.
- **`rx_read`:** clears `rx_valid` when no delivery happens in that cycle. It has no effect when `rx_valid == 0`, and `rx_data` is unchanged.
- **`rx_clear_err`:** clears both error flags. If an error-setting event occurs in the same cycle, the set wins.
- **Reset values:** `rx_data = 0`, `rx_valid = 0`, `rx_overrun = 0`, `rx_frame_err = 0`, `rx_busy = 0`, state IDLE, `cnt = 0`, shift register = 0.
- **Reset mid-frame:** abandons the frame with no flag. Until `rxs` returns high, the remaining line activity can be mistaken for a start bit. The upper layer accepts this.

## Timing
- Let T be the first cycle `uart_rxd` is low. `rxs` is low at T+2, and IDLE exits on that edge.
- Sample points are at T+2+CPB/2 (start bit) and then every CPB cycles: data bits 0..7, then the stop bit at T+2+CPB/2+9·CPB.
- `rx_valid` (or the error flag) rises at T+3+CPB/2+9·CPB.
- `rx_busy` rises at T+3 and falls together with the delivery.
- `rx_valid` falls the cycle after the `rx_read` pulse.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package (`debug_uart_pkg`) holds:
  - the state encoding localparams (IDLE, START, DATA, STOP, BREAK; 3 bits);
  - the `CPB` derivation function, reused by the transmitter.
- One sub-module, `uart_rx_sync`: a 2-flop synchroniser with a reset value parameter (reset to 1 here).
- The FSM, counter, shift register and holding register live in `debug_uart_rx`.

## Test plan
All scenarios use `CLK_HZ=16`, `BIT_RATE=1` (CPB=16) unless noted.
- **Single byte:** send 0xA5 as 8N1 starting at T.
  - `rx_valid` rises at exactly T+3+8+144 = T+155 with `rx_data = 0xA5`; no flags.
  - Pulse `rx_read`: `rx_valid = 0` on the next cycle.
- **Glitch:** drive `uart_rxd` low for 4 cycles, then high.
  - `rx_busy` pulses, then the FSM returns to IDLE.
  - No `rx_valid`, no flags.
- **Overrun:** send 0x11 then 0x22 back-to-back without reading.
  - `rx_data = 0x11`, `rx_overrun = 1`.
  - `rx_read` in the exact cycle 0x22 delivers (separate run): `rx_data = 0x22`, no overrun.
- **Framing/break:** send 0x5A with the stop bit low, then hold the line low for 100 cycles.
  - One `rx_frame_err`, no `rx_valid`, stays in BREAK until high.
  - `rx_clear_err` clears the flag.
- **Back-to-back stream:** 0x00, 0xFF, 0x55 with no idle gap, each read promptly → all three received in order, no flags.
- **Mid-frame reset:** assert `rst` for 1 cycle during data bit 3.
  - All outputs at reset values on the next cycle.
  - A subsequent clean 0x3C is received correctly.
